// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : otter_fetch_queue
//  Description : Instruction fetch unit with a circular {pc, instr} queue
//                between a one-cycle-latency instruction memory and decode.
//                Issues one read per cycle while the queue can absorb the
//                response, and flushes on REDIRECT.
//                Optional macro OTTER_FQ_BYPASS_EN: a response arriving into
//                an empty queue is forwarded to decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    output logic [XLEN-1:0]          IMEM_ADDR,
    output logic                     IMEM_RDEN,
    input  logic [XLEN-1:0]          IMEM_DOUT,
    input  logic                     REDIRECT,
    input  logic [XLEN-1:0]          REDIRECT_PC,
    output logic                     DE_VALID,
    input  logic                     DE_READY,
    output logic [XLEN-1:0]          DE_IR,
    output logic [XLEN-1:0]          DE_PC,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int                c_PTR_W     = $clog2(DEPTH);
    localparam int                c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]   c_PC_STEP   = XLEN'(4);

    // Architectural state
    logic [XLEN-1:0]    r_fetch_pc;      // next sequential fetch address
    logic               r_inflight;      // a read was issued last cycle
    logic [XLEN-1:0]    r_inflight_pc;   // address of that read
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [XLEN-1:0]    r_q_pc [DEPTH];
    logic [XLEN-1:0]    r_q_ir [DEPTH];

    // Datapath / control wires
    logic               w_resp;          // live response arriving this cycle
    logic               w_bypass;        // response forwarded straight to decode
    logic               w_pop;           // decode handshake
    logic               w_q_push;
    logic               w_q_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic [XLEN-1:0]    w_redir_pc;

    // Decode-side view: queue head, or the arriving response when bypassing
    always_comb begin
        w_resp     = r_inflight && !REDIRECT;
        w_redir_pc = {REDIRECT_PC[XLEN-1:2], 2'b00};
`ifdef OTTER_FQ_BYPASS_EN
        w_bypass = (r_count == '0) && w_resp;
        DE_IR    = w_bypass ? IMEM_DOUT     : r_q_ir[r_rd_ptr];
        DE_PC    = w_bypass ? r_inflight_pc : r_q_pc[r_rd_ptr];
`else
        w_bypass = 1'b0;
        DE_IR    = r_q_ir[r_rd_ptr];
        DE_PC    = r_q_pc[r_rd_ptr];
`endif
        DE_VALID = RESET_N && !REDIRECT && ((r_count != '0) || w_bypass);
        w_pop    = DE_VALID && DE_READY;
        // A bypassed instruction consumed by decode never enters the queue
        w_q_pop  = w_pop && !w_bypass;
        w_q_push = w_resp && !(w_bypass && DE_READY);
        w_count_next = r_count + {{(c_CNT_W-1){1'b0}}, w_q_push}
                               - {{(c_CNT_W-1){1'b0}}, w_q_pop};
        // Issue only if the response is guaranteed a slot when it returns
        IMEM_RDEN = RESET_N && (REDIRECT || (w_count_next < c_DEPTH_CNT));
        IMEM_ADDR = REDIRECT ? w_redir_pc : r_fetch_pc;
    end

    assign COUNT = r_count;

    // Fetch PC, in-flight tracking, pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_fetch_pc    <= RESET_VEC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_VEC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight    <= IMEM_RDEN;
            r_inflight_pc <= IMEM_ADDR;
            if (IMEM_RDEN) begin
                r_fetch_pc <= IMEM_ADDR + c_PC_STEP;
            end
            if (REDIRECT) begin
                // Flush everything fetched so far; the response arriving now
                // belongs to the old stream and is dropped.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_q_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_q_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;
            end
        end
    end

    // Queue storage; contents are only meaningful below r_count
    always_ff @(posedge CLK) begin
        if (RESET_N && w_q_push) begin
            r_q_pc[r_wr_ptr] <= r_inflight_pc;
            r_q_ir[r_wr_ptr] <= IMEM_DOUT;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_fetch_queue
//  Description : Self-checking bench for otter_fetch_queue: directed vector
//                table, hand-written corner sequences, and a randomized run
//                checked against a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_queue;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RDEN;
    logic [31:0] IMEM_DOUT;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DE_VALID;
    logic        DE_READY;
    logic [31:0] DE_IR;
    logic [31:0] DE_PC;
    logic [2:0]  COUNT;

    otter_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VEC(RVEC)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_RDEN(IMEM_RDEN), .IMEM_DOUT(IMEM_DOUT),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .DE_VALID(DE_VALID), .DE_READY(DE_READY),
        .DE_IR(DE_IR), .DE_PC(DE_PC), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] key = 32'h0;   // memory content = address ^ key

    // Instruction memory: one-cycle read latency, garbage when not read
    always @(posedge CLK) begin
        IMEM_DOUT <= IMEM_RDEN ? (IMEM_ADDR ^ key) : $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: address stream issued to memory and the
    // in-order instruction stream that decode must see.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_exp_pc;
    int          m_prev_rden;

    task automatic model_step();
        int pop;
        int occ;
        if (!RESET_N) begin
            chk("rst_rden", {31'b0, IMEM_RDEN}, 32'd0);
            chk("rst_valid", {31'b0, DE_VALID}, 32'd0);
            m_fetch_pc  = RVEC;
            m_exp_pc    = RVEC;
            m_prev_rden = 0;
        end else begin
            pop = (DE_VALID && DE_READY) ? 1 : 0;
            chk("valid_rule", {31'b0, DE_VALID}, {31'b0, (COUNT != 0) && !REDIRECT});
            if (COUNT > 3'(DEPTH)) chk("count_max", {29'b0, COUNT}, DEPTH);
            if (REDIRECT) begin
                chk("redir_rden", {31'b0, IMEM_RDEN}, 32'd1);
                chk("redir_addr", IMEM_ADDR, {REDIRECT_PC[31:2], 2'b00});
                m_fetch_pc = {REDIRECT_PC[31:2], 2'b00} + 32'd4;
                m_exp_pc   = {REDIRECT_PC[31:2], 2'b00};
            end else begin
                occ = int'(COUNT) + m_prev_rden - pop;
                chk("rden_rule", {31'b0, IMEM_RDEN}, {31'b0, occ < DEPTH});
                if (IMEM_RDEN) begin
                    chk("fetch_addr", IMEM_ADDR, m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                if (pop != 0) begin
                    chk("stream_pc", DE_PC, m_exp_pc);
                    chk("stream_ir", DE_IR, m_exp_pc ^ key);
                    m_exp_pc = m_exp_pc + 32'd4;
                end
            end
            m_prev_rden = IMEM_RDEN ? 1 : 0;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic advance();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_rden;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_count;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // rst, rdy, redir, rpc, rden, addr, valid, pc, count
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   3'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   3'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   3'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4,   3'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8,   3'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8,   3'd2};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   3'd3};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   3'd4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   3'd4};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h8,   3'd4};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'hC,   3'd3};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h10,  3'd3};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h102, 1'b1, 32'h100, 1'b0, 32'h0,   3'd3};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   3'd0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 3'd1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104, 3'd1};

        RESET_N     = 1'b0;
        DE_READY    = 1'b1;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        m_fetch_pc  = RVEC;
        m_exp_pc    = RVEC;
        m_prev_rden = 0;
        @(posedge CLK);
        #1;
        cyc();
        cyc();

        // Directed vector table: startup, stall/fill, resume, redirect
        for (int i = 0; i < 17; i++) begin
            RESET_N     = tbl[i].rst_n;
            DE_READY    = tbl[i].ready;
            REDIRECT    = tbl[i].redir;
            REDIRECT_PC = tbl[i].rpc;
            settle();
            chk($sformatf("tbl%0d_rden", i), {31'b0, IMEM_RDEN}, {31'b0, tbl[i].e_rden});
            if (tbl[i].e_rden) chk($sformatf("tbl%0d_addr", i), IMEM_ADDR, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, DE_VALID}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), DE_PC, tbl[i].e_pc);
                chk($sformatf("tbl%0d_ir", i), DE_IR, tbl[i].e_pc);
            end
            chk($sformatf("tbl%0d_count", i), {29'b0, COUNT}, {29'b0, tbl[i].e_count});
            advance();
        end
        REDIRECT = 1'b0;

        // Back-to-back redirects: only the last target reaches decode
        REDIRECT = 1'b1; REDIRECT_PC = 32'h200; cyc();
        REDIRECT = 1'b1; REDIRECT_PC = 32'h300; cyc();
        REDIRECT = 1'b0;
        settle();
        chk("b2b_valid_t2", {31'b0, DE_VALID}, 32'd0);
        advance();
        settle();
        chk("b2b_valid_t3", {31'b0, DE_VALID}, 32'd1);
        chk("b2b_first_pc", DE_PC, 32'h300);
        advance();
        for (int i = 0; i < 4; i++) cyc();

        // PC wrap at the top of the address space
        REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC; cyc();
        REDIRECT = 1'b0;
        cyc();
        settle();
        chk("wrap_pc_top", DE_PC, 32'hFFFF_FFFC);
        advance();
        settle();
        chk("wrap_pc_zero", DE_PC, 32'h0000_0000);
        advance();

        // Reset mid-stream with entries queued
        DE_READY = 1'b0;
        cyc();
        cyc();
        settle();
        chk("pre_rst_count_ge2", {31'b0, COUNT >= 3'd2}, 32'd1);
        advance();
        RESET_N = 1'b0; cyc();
        RESET_N = 1'b1; DE_READY = 1'b1;
        settle();
        chk("post_rst_count", {29'b0, COUNT}, 32'd0);
        chk("post_rst_valid", {31'b0, DE_VALID}, 32'd0);
        chk("post_rst_rden", {31'b0, IMEM_RDEN}, 32'd1);
        chk("post_rst_addr", IMEM_ADDR, RVEC);
        advance();
        cyc();
        settle();
        chk("post_rst_first_pc", DE_PC, RVEC);
        chk("post_rst_first_valid", {31'b0, DE_VALID}, 32'd1);
        advance();

        // Randomized traffic against the reference model
        RESET_N = 1'b0;
        key     = $urandom;
        cyc();
        RESET_N = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            RESET_N     = ($urandom_range(0, 199) != 0);
            DE_READY    = ($urandom_range(0, 9) < 7);
            REDIRECT    = ($urandom_range(0, 19) == 0);
            REDIRECT_PC = $urandom;
            if (i % 500 == 0) DE_READY = 1'b0;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
